// File: rtl/md_rs_issue.sv
// md_rs_issue: multiply/divide reservation station with CDB wakeup and oldest-ready issue.
// Optional build macro MD_RS_PERF_EN adds issue and full-cycle performance counters.
module md_rs_issue #(
  parameter int DEPTH      = 4,
  parameter int NUM_CDB    = 2,
  parameter int DATA_W     = 32,
  parameter int PRF_IDX_W  = 6,
  parameter int ROB_IDX_W  = 5,
  parameter int ARCH_IDX_W = 5,
  parameter int OPC_W      = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic                           disp_valid_i,
  output logic                           disp_ready_o,
  input  logic [OPC_W-1:0]               disp_opcode_i,
  input  logic [ROB_IDX_W-1:0]           disp_rob_id_i,
  input  logic [ARCH_IDX_W-1:0]          disp_rd_arch_i,
  input  logic [PRF_IDX_W-1:0]           disp_rd_phy_i,
  input  logic [PRF_IDX_W-1:0]           disp_rs1_phy_i,
  input  logic [PRF_IDX_W-1:0]           disp_rs2_phy_i,
  input  logic                           disp_rs1_rdy_i,
  input  logic                           disp_rs2_rdy_i,
  input  logic [DATA_W-1:0]              disp_rs1_value_i,
  input  logic [DATA_W-1:0]              disp_rs2_value_i,
  input  logic [NUM_CDB-1:0]             cdb_valid_i,
  input  logic [NUM_CDB*PRF_IDX_W-1:0]   cdb_rd_phy_i,
  input  logic [NUM_CDB*DATA_W-1:0]      cdb_rd_value_i,
  output logic                           iss_valid_o,
  input  logic                           iss_ready_i,
  output logic [OPC_W-1:0]               iss_opcode_o,
  output logic [ROB_IDX_W-1:0]           iss_rob_id_o,
  output logic [ARCH_IDX_W-1:0]          iss_rd_arch_o,
  output logic [PRF_IDX_W-1:0]           iss_rd_phy_o,
  output logic [DATA_W-1:0]              iss_rs1_value_o,
  output logic [DATA_W-1:0]              iss_rs2_value_o
`ifdef MD_RS_PERF_EN
  ,
  output logic [31:0]                    perf_issue_cnt_o,
  output logic [31:0]                    perf_full_cyc_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [OPC_W-1:0]      opcode;
    logic [ROB_IDX_W-1:0]  rob_id;
    logic [ARCH_IDX_W-1:0] rd_arch;
    logic [PRF_IDX_W-1:0]  rd_phy;
    logic [PRF_IDX_W-1:0]  rs1_phy;
    logic                  rs1_rdy;
    logic [DATA_W-1:0]     rs1_val;
    logic [PRF_IDX_W-1:0]  rs2_phy;
    logic                  rs2_rdy;
    logic [DATA_W-1:0]     rs2_val;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  entry_t            woke  [DEPTH];
  entry_t            disp_ent;
  entry_t            disp_woke;
  logic [CNT_W-1:0]  count_q, count_d, count_mid;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_found;
  logic              issue_load;
  logic              disp_fire;

  logic                  iss_valid_q;
  logic [OPC_W-1:0]      iss_opcode_q;
  logic [ROB_IDX_W-1:0]  iss_rob_id_q;
  logic [ARCH_IDX_W-1:0] iss_rd_arch_q;
  logic [PRF_IDX_W-1:0]  iss_rd_phy_q;
  logic [DATA_W-1:0]     iss_rs1_value_q;
  logic [DATA_W-1:0]     iss_rs2_value_q;

  // Descending port scan so the lowest-numbered matching CDB port wins.
  function automatic entry_t wake(input entry_t e);
    entry_t w;
    w = e;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (!e.rs1_rdy && cdb_valid_i[p] && cdb_rd_phy_i[p*PRF_IDX_W +: PRF_IDX_W] == e.rs1_phy) begin
        w.rs1_rdy = 1'b1;
        w.rs1_val = cdb_rd_value_i[p*DATA_W +: DATA_W];
      end
      if (!e.rs2_rdy && cdb_valid_i[p] && cdb_rd_phy_i[p*PRF_IDX_W +: PRF_IDX_W] == e.rs2_phy) begin
        w.rs2_rdy = 1'b1;
        w.rs2_val = cdb_rd_value_i[p*DATA_W +: DATA_W];
      end
    end
    return w;
  endfunction

  // Handshakes: a transfer happens on a rising edge where valid && ready; once the
  // issue register is valid its payload stays stable until iss_ready_i accepts it.
  assign disp_ready_o = (count_q != CNT_W'(DEPTH));
  assign disp_fire    = disp_valid_i && disp_ready_o;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (CNT_W'(i) < count_q && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_load = sel_found && (!iss_valid_q || iss_ready_i) && !flush_i;
  assign count_mid  = count_q - CNT_W'(issue_load);

  always_comb begin
    disp_ent.opcode  = disp_opcode_i;
    disp_ent.rob_id  = disp_rob_id_i;
    disp_ent.rd_arch = disp_rd_arch_i;
    disp_ent.rd_phy  = disp_rd_phy_i;
    disp_ent.rs1_phy = disp_rs1_phy_i;
    disp_ent.rs1_rdy = disp_rs1_rdy_i;
    disp_ent.rs1_val = disp_rs1_value_i;
    disp_ent.rs2_phy = disp_rs2_phy_i;
    disp_ent.rs2_rdy = disp_rs2_rdy_i;
    disp_ent.rs2_val = disp_rs2_value_i;
    disp_woke        = wake(disp_ent);
  end

  // Collapse above the issued slot first, then append at the post-collapse count.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      woke[j]  = wake(ent_q[j]);
      ent_d[j] = woke[j];
    end
    for (int j = 0; j < DEPTH - 1; j++) begin
      if (issue_load && IDX_W'(j) >= sel_idx) ent_d[j] = woke[j+1];
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (disp_fire && CNT_W'(j) == count_mid) ent_d[j] = disp_woke;
    end
    count_d = flush_i ? '0 : count_mid + CNT_W'(disp_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q         <= '0;
      for (int j = 0; j < DEPTH; j++) ent_q[j] <= '0;
      iss_valid_q     <= 1'b0;
      iss_opcode_q    <= '0;
      iss_rob_id_q    <= '0;
      iss_rd_arch_q   <= '0;
      iss_rd_phy_q    <= '0;
      iss_rs1_value_q <= '0;
      iss_rs2_value_q <= '0;
    end else begin
      count_q <= count_d;
      for (int j = 0; j < DEPTH; j++) ent_q[j] <= ent_d[j];
      if (flush_i) begin
        iss_valid_q <= 1'b0;
      end else if (issue_load) begin
        iss_valid_q     <= 1'b1;
        iss_opcode_q    <= ent_q[sel_idx].opcode;
        iss_rob_id_q    <= ent_q[sel_idx].rob_id;
        iss_rd_arch_q   <= ent_q[sel_idx].rd_arch;
        iss_rd_phy_q    <= ent_q[sel_idx].rd_phy;
        iss_rs1_value_q <= ent_q[sel_idx].rs1_val;
        iss_rs2_value_q <= ent_q[sel_idx].rs2_val;
      end else if (iss_ready_i) begin
        iss_valid_q <= 1'b0;
      end
    end
  end

  assign iss_valid_o     = iss_valid_q;
  assign iss_opcode_o    = iss_opcode_q;
  assign iss_rob_id_o    = iss_rob_id_q;
  assign iss_rd_arch_o   = iss_rd_arch_q;
  assign iss_rd_phy_o    = iss_rd_phy_q;
  assign iss_rs1_value_o = iss_rs1_value_q;
  assign iss_rs2_value_o = iss_rs2_value_q;

`ifdef MD_RS_PERF_EN
  logic [31:0] perf_issue_cnt_q;
  logic [31:0] perf_full_cyc_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_cnt_q <= '0;
      perf_full_cyc_q  <= '0;
    end else begin
      if (iss_valid_q && iss_ready_i) perf_issue_cnt_q <= perf_issue_cnt_q + 32'd1;
      if (count_q == CNT_W'(DEPTH))   perf_full_cyc_q  <= perf_full_cyc_q + 32'd1;
    end
  end

  assign perf_issue_cnt_o = perf_issue_cnt_q;
  assign perf_full_cyc_o  = perf_full_cyc_q;
`endif

endmodule

// File: tb/tb_md_rs_issue.sv
// tb_md_rs_issue: directed scenarios plus randomized traffic for md_rs_issue,
// checked every cycle against a queue-based behavioural model of the station.
module tb_md_rs_issue;
  localparam int DEPTH   = 4;
  localparam int NUM_CDB = 2;
  localparam int DW      = 32;
  localparam int PW      = 6;
  localparam int RW      = 5;
  localparam int AW      = 5;
  localparam int OW      = 3;
  localparam int PAY_W   = OW + RW + AW + PW + 2 * DW;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    flush = 1'b0;
  logic                    disp_valid = 1'b0;
  logic                    disp_ready;
  logic [OW-1:0]           disp_opcode = '0;
  logic [RW-1:0]           disp_rob_id = '0;
  logic [AW-1:0]           disp_rd_arch = '0;
  logic [PW-1:0]           disp_rd_phy = '0;
  logic [PW-1:0]           disp_rs1_phy = '0;
  logic [PW-1:0]           disp_rs2_phy = '0;
  logic                    disp_rs1_rdy = 1'b0;
  logic                    disp_rs2_rdy = 1'b0;
  logic [DW-1:0]           disp_rs1_value = '0;
  logic [DW-1:0]           disp_rs2_value = '0;
  logic [NUM_CDB-1:0]      cdb_valid = '0;
  logic [NUM_CDB*PW-1:0]   cdb_rd_phy = '0;
  logic [NUM_CDB*DW-1:0]   cdb_rd_value = '0;
  logic                    iss_valid;
  logic                    iss_ready = 1'b0;
  logic [OW-1:0]           iss_opcode;
  logic [RW-1:0]           iss_rob_id;
  logic [AW-1:0]           iss_rd_arch;
  logic [PW-1:0]           iss_rd_phy;
  logic [DW-1:0]           iss_rs1_value;
  logic [DW-1:0]           iss_rs2_value;
  logic [PAY_W-1:0]        dut_pay;
`ifdef MD_RS_PERF_EN
  logic [31:0]             perf_issue_cnt;
  logic [31:0]             perf_full_cyc;
`endif

  always #5 clk = ~clk;

  md_rs_issue dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush),
    .disp_valid_i     (disp_valid),
    .disp_ready_o     (disp_ready),
    .disp_opcode_i    (disp_opcode),
    .disp_rob_id_i    (disp_rob_id),
    .disp_rd_arch_i   (disp_rd_arch),
    .disp_rd_phy_i    (disp_rd_phy),
    .disp_rs1_phy_i   (disp_rs1_phy),
    .disp_rs2_phy_i   (disp_rs2_phy),
    .disp_rs1_rdy_i   (disp_rs1_rdy),
    .disp_rs2_rdy_i   (disp_rs2_rdy),
    .disp_rs1_value_i (disp_rs1_value),
    .disp_rs2_value_i (disp_rs2_value),
    .cdb_valid_i      (cdb_valid),
    .cdb_rd_phy_i     (cdb_rd_phy),
    .cdb_rd_value_i   (cdb_rd_value),
    .iss_valid_o      (iss_valid),
    .iss_ready_i      (iss_ready),
    .iss_opcode_o     (iss_opcode),
    .iss_rob_id_o     (iss_rob_id),
    .iss_rd_arch_o    (iss_rd_arch),
    .iss_rd_phy_o     (iss_rd_phy),
    .iss_rs1_value_o  (iss_rs1_value),
    .iss_rs2_value_o  (iss_rs2_value)
`ifdef MD_RS_PERF_EN
    ,
    .perf_issue_cnt_o (perf_issue_cnt),
    .perf_full_cyc_o  (perf_full_cyc)
`endif
  );

  assign dut_pay = {iss_opcode, iss_rob_id, iss_rd_arch, iss_rd_phy, iss_rs1_value, iss_rs2_value};

  // ---------------- reference model ----------------
  typedef struct {
    logic [OW-1:0] opc;
    logic [RW-1:0] rob;
    logic [AW-1:0] arch;
    logic [PW-1:0] rd;
    logic [PW-1:0] p1;
    logic [PW-1:0] p2;
    bit            r1;
    bit            r2;
    logic [DW-1:0] v1;
    logic [DW-1:0] v2;
  } uop_t;

  uop_t             mq[$];
  bit               m_iss_valid;
  logic [PAY_W-1:0] m_iss_pay;
  logic [PAY_W-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic uop_t wake_src(input uop_t u);
    uop_t w;
    w = u;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (!w.r1 && cdb_valid[p] && cdb_rd_phy[p*PW +: PW] == w.p1) begin
        w.r1 = 1'b1;
        w.v1 = cdb_rd_value[p*DW +: DW];
      end
      if (!w.r2 && cdb_valid[p] && cdb_rd_phy[p*PW +: PW] == w.p2) begin
        w.r2 = 1'b1;
        w.v2 = cdb_rd_value[p*DW +: DW];
      end
    end
    return w;
  endfunction

  function automatic logic [PAY_W-1:0] pack(input uop_t u);
    return {u.opc, u.rob, u.arch, u.rd, u.v1, u.v2};
  endfunction

  // Compare registered outputs, advance the model with the current inputs, take one edge.
  task automatic step();
    int   sel;
    bit   load;
    bit   fire;
    uop_t nu;
    check("disp_ready", 128'(disp_ready), 128'(mq.size() != DEPTH));
    check("iss_valid", 128'(iss_valid), 128'(m_iss_valid));
    check("iss_pay", 128'(dut_pay), 128'(m_iss_pay));
    if (m_iss_valid && iss_ready && exp_q.size() > 0) check("accept", 128'(dut_pay), 128'(exp_q.pop_front()));
    fire = disp_valid && (mq.size() != DEPTH);
    sel = -1;
    for (int i = 0; i < mq.size(); i++) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
    if (flush) begin
      if (m_iss_valid && !iss_ready && exp_q.size() > 0) void'(exp_q.pop_back());
      mq.delete();
      m_iss_valid = 1'b0;
    end else begin
      load = (sel >= 0) && (!m_iss_valid || iss_ready);
      for (int i = 0; i < mq.size(); i++) mq[i] = wake_src(mq[i]);
      if (load) begin
        m_iss_pay = pack(mq[sel]);
        exp_q.push_back(m_iss_pay);
        mq.delete(sel);
        m_iss_valid = 1'b1;
      end else if (m_iss_valid && iss_ready) begin
        m_iss_valid = 1'b0;
      end
      if (fire) begin
        nu.opc = disp_opcode;   nu.rob = disp_rob_id; nu.arch = disp_rd_arch; nu.rd = disp_rd_phy;
        nu.p1  = disp_rs1_phy;  nu.r1  = disp_rs1_rdy; nu.v1  = disp_rs1_value;
        nu.p2  = disp_rs2_phy;  nu.r2  = disp_rs2_rdy; nu.v2  = disp_rs2_value;
        mq.push_back(wake_src(nu));
      end
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_disp(input logic [OW-1:0] opc, input logic [RW-1:0] rob,
                            input logic [PW-1:0] p1, input bit r1, input logic [DW-1:0] v1,
                            input logic [PW-1:0] p2, input bit r2, input logic [DW-1:0] v2);
    disp_valid     = 1'b1;
    disp_opcode    = opc;
    disp_rob_id    = rob;
    disp_rd_arch   = rob;
    disp_rd_phy    = {1'b1, rob};
    disp_rs1_phy   = p1;
    disp_rs1_rdy   = r1;
    disp_rs1_value = v1;
    disp_rs2_phy   = p2;
    disp_rs2_rdy   = r2;
    disp_rs2_value = v2;
  endtask

  task automatic drive_cdb(input int port, input logic [PW-1:0] phy, input logic [DW-1:0] val);
    cdb_valid[port]            = 1'b1;
    cdb_rd_phy[port*PW +: PW]  = phy;
    cdb_rd_value[port*DW +: DW] = val;
  endtask

  task automatic idle_inputs();
    disp_valid = 1'b0;
    cdb_valid  = '0;
    flush      = 1'b0;
  endtask

  localparam logic [DW-1:0] JUNK = 32'hBAD0_0BAD;

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    m_iss_valid = 1'b0;
    m_iss_pay   = '0;
    repeat (2) @(negedge clk);
    check("rst_disp_ready", 128'(disp_ready), 128'd1);
    check("rst_iss_valid", 128'(iss_valid), 128'd0);
    check("rst_iss_pay", 128'(dut_pay), 128'd0);
    rst = 1'b0;

    // 1: both sources ready at dispatch
    iss_ready = 1'b1;
    drive_disp(3'd4, 5'd1, 6'd1, 1'b1, 32'd100, 6'd2, 1'b1, 32'd7);
    step();
    idle_inputs();
    check("t1_not_yet", 128'(iss_valid), 128'd0);
    step();
    check("t1_valid", 128'(iss_valid), 128'd1);
    check("t1_rs1", 128'(iss_rs1_value), 128'd100);
    check("t1_rs2", 128'(iss_rs2_value), 128'd7);
    step();

    // 2: rs2 woken by CDB port 0 after three idle cycles
    drive_disp(3'd0, 5'd2, 6'd3, 1'b1, 32'h11, 6'd12, 1'b0, JUNK);
    step();
    idle_inputs();
    repeat (3) begin
      check("t2_idle", 128'(iss_valid), 128'd0);
      step();
    end
    drive_cdb(0, 6'd12, 32'h5);
    step();
    idle_inputs();
    check("t2_c1", 128'(iss_valid), 128'd0);
    step();
    check("t2_valid", 128'(iss_valid), 128'd1);
    check("t2_rs2", 128'(iss_rs2_value), 128'h5);
    step();

    // 3: dispatch bypass from CDB port 1
    drive_disp(3'd1, 5'd3, 6'd9, 1'b0, JUNK, 6'd4, 1'b1, 32'h22);
    drive_cdb(1, 6'd9, 32'hDEAD_BEEF);
    step();
    idle_inputs();
    step();
    check("t3_valid", 128'(iss_valid), 128'd1);
    check("t3_rs1", 128'(iss_rs1_value), 128'hDEAD_BEEF);
    step();

    // 4: full queue, wake a middle entry, then the rest in order
    for (int k = 0; k < 4; k++) begin
      drive_disp(3'd2, 5'(k), 6'(20 + k), 1'b0, JUNK, 6'd5, 1'b1, 32'(k));
      step();
    end
    idle_inputs();
    check("t4_full", 128'(disp_ready), 128'd0);
    drive_cdb(0, 6'd22, 32'h222);
    step();
    idle_inputs();
    step();
    check("t4_first_valid", 128'(iss_valid), 128'd1);
    check("t4_first_rob", 128'(iss_rob_id), 128'd2);
    check("t4_ready_again", 128'(disp_ready), 128'd1);
    drive_cdb(0, 6'd20, 32'h200);
    drive_cdb(1, 6'd21, 32'h211);
    step();
    idle_inputs();
    check("t4_gap", 128'(iss_valid), 128'd0);
    drive_cdb(0, 6'd23, 32'h233);
    step();
    idle_inputs();
    check("t4_rob0", 128'(iss_rob_id), 128'd0);
    step();
    check("t4_rob1", 128'(iss_rob_id), 128'd1);
    step();
    check("t4_rob3", 128'(iss_rob_id), 128'd3);
    check("t4_rob3_rs1", 128'(iss_rs1_value), 128'h233);
    step();
    check("t4_empty", 128'(iss_valid), 128'd0);

    // 5: backpressure holds the older uop
    iss_ready = 1'b0;
    drive_disp(3'd3, 5'd10, 6'd1, 1'b1, 32'hA, 6'd2, 1'b1, 32'hB);
    step();
    drive_disp(3'd3, 5'd11, 6'd1, 1'b1, 32'hC, 6'd2, 1'b1, 32'hD);
    step();
    idle_inputs();
    repeat (5) begin
      check("t5_hold_valid", 128'(iss_valid), 128'd1);
      check("t5_hold_rob", 128'(iss_rob_id), 128'd10);
      check("t5_hold_rs1", 128'(iss_rs1_value), 128'hA);
      step();
    end
    iss_ready = 1'b1;
    step();
    check("t5_next_rob", 128'(iss_rob_id), 128'd11);
    check("t5_next_valid", 128'(iss_valid), 128'd1);
    step();
    check("t5_drained", 128'(iss_valid), 128'd0);

    // 6: flush with a full queue and a stalled issue register
    iss_ready = 1'b0;
    drive_disp(3'd5, 5'd20, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2);
    step();
    for (int k = 0; k < 4; k++) begin
      drive_disp(3'd5, 5'(21 + k), 6'(30 + k), 1'b0, JUNK, 6'd2, 1'b1, 32'h3);
      step();
    end
    idle_inputs();
    check("t6_full", 128'(disp_ready), 128'd0);
    check("t6_stalled", 128'(iss_valid), 128'd1);
    drive_disp(3'd5, 5'd25, 6'd1, 1'b1, 32'h4, 6'd2, 1'b1, 32'h5);
    flush = 1'b1;
    step();
    idle_inputs();
    check("t6_flush_valid", 128'(iss_valid), 128'd0);
    check("t6_flush_ready", 128'(disp_ready), 128'd1);
    iss_ready = 1'b1;
    drive_cdb(0, 6'd30, 32'h30);
    drive_cdb(1, 6'd31, 32'h31);
    step();
    drive_cdb(0, 6'd32, 32'h32);
    drive_cdb(1, 6'd33, 32'h33);
    step();
    idle_inputs();
    repeat (3) begin
      check("t6_no_issue", 128'(iss_valid), 128'd0);
      step();
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      disp_valid     = 1'($urandom_range(0, 1));
      disp_opcode    = 3'($urandom_range(0, 7));
      disp_rob_id    = 5'($urandom_range(0, 31));
      disp_rd_arch   = 5'($urandom_range(0, 31));
      disp_rd_phy    = 6'($urandom_range(0, 63));
      disp_rs1_phy   = 6'($urandom_range(0, 7));
      disp_rs2_phy   = 6'($urandom_range(0, 7));
      disp_rs1_rdy   = 1'($urandom_range(0, 1));
      disp_rs2_rdy   = 1'($urandom_range(0, 1));
      disp_rs1_value = $urandom;
      disp_rs2_value = $urandom;
      cdb_valid      = 2'($urandom_range(0, 3));
      cdb_rd_phy     = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      cdb_rd_value   = {$urandom, $urandom};
      iss_ready      = ($urandom_range(0, 9) < 7);
      flush          = ($urandom_range(0, 59) == 0);
      step();
    end
    idle_inputs();
    iss_ready = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
